// File: rtl/dcache_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dcache_mem_responder
// Brief    : Memory-side responder for the L1 data cache. Fills whole lines
//            word-by-word from a word-wide backing port and drains byte-enabled
//            stores through a small FIFO. Stores always drain before a pending
//            line fill. Optional performance counters are enabled by the macro
//            DCACHE_MEM_RESP_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_mem_responder #(
  parameter int TAG_W       = 21,
  parameter int INDEX_W     = 7,
  parameter int WORDS_LOG   = 3,
  parameter int ST_FIFO_LOG = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [TAG_W+INDEX_W-1:0]         dc2memLdAddr_i,
  input  logic                             dc2memLdValid_i,
  output logic [TAG_W-1:0]                 mem2dcLdTag_o,
  output logic [INDEX_W-1:0]               mem2dcLdIndex_o,
  output logic [(32<<WORDS_LOG)-1:0]       mem2dcLdData_o,
  output logic                             mem2dcLdValid_o,
  input  logic [TAG_W+INDEX_W+WORDS_LOG-1:0] dc2memStAddr_i,
  input  logic [31:0]                      dc2memStData_i,
  input  logic [3:0]                       dc2memStByteEn_i,
  input  logic                             dc2memStValid_i,
  output logic                             mem2dcStComplete_o,
  output logic                             mem2dcStStall_o,
  output logic                             memRdEn_o,
  output logic [TAG_W+INDEX_W+WORDS_LOG-1:0] memRdAddr_o,
  input  logic [31:0]                      memRdData_i,
  input  logic                             memRdValid_i,
  output logic                             memWrEn_o,
  output logic [TAG_W+INDEX_W+WORDS_LOG-1:0] memWrAddr_o,
  output logic [31:0]                      memWrData_o,
  output logic [3:0]                       memWrByteEn_o,
  input  logic                             memWrAck_i
`ifdef DCACHE_MEM_RESP_PERF_EN
  ,
  output logic [31:0]                      perfLdLines_o,
  output logic [31:0]                      perfStores_o,
  output logic [31:0]                      perfStStallCyc_o
`endif
);

  localparam int c_LINE_A_W = TAG_W + INDEX_W;
  localparam int c_WORD_A_W = TAG_W + INDEX_W + WORDS_LOG;
  localparam int c_WORDS    = 1 << WORDS_LOG;
  localparam int c_DEPTH    = 1 << ST_FIFO_LOG;
  localparam logic [ST_FIFO_LOG:0] c_DEPTH_CNT = (ST_FIFO_LOG+1)'(c_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ST_REQ  = 3'd1,
    S_LD_REQ  = 3'd2,
    S_LD_WAIT = 3'd3,
    S_LD_RESP = 3'd4
  } stateT;

  stateT                        r_state;
  logic [WORDS_LOG-1:0]         r_beat;
  logic                         r_ldPending;
  logic [c_LINE_A_W-1:0]        r_ldAddr;
  logic [c_WORDS-1:0][31:0]     r_lineBuf;

  logic [c_WORD_A_W-1:0]        r_fifoAddr [c_DEPTH];
  logic [31:0]                  r_fifoData [c_DEPTH];
  logic [3:0]                   r_fifoBe   [c_DEPTH];
  logic [ST_FIFO_LOG-1:0]       r_wrPtr;
  logic [ST_FIFO_LOG-1:0]       r_rdPtr;
  logic [ST_FIFO_LOG:0]         r_count;

  logic                         w_full;
  logic                         w_stall;
  logic                         w_push;
  logic                         w_pop;
  logic [WORDS_LOG-1:0]         w_beatNext;

  // Stall holds new stores while full or while a fill is waiting, so any
  // queued store is always older than the pending load.
  assign w_full          = (r_count == c_DEPTH_CNT);
  assign w_stall         = w_full | r_ldPending;
  assign mem2dcStStall_o = w_stall;
  assign w_push          = dc2memStValid_i & ~w_stall;
  assign w_pop           = (r_state == S_ST_REQ) & memWrAck_i;
  assign w_beatNext      = r_beat + 1'b1;

  // Store FIFO payload; storage needs no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoAddr[r_wrPtr] <= dc2memStAddr_i;
      r_fifoData[r_wrPtr] <= dc2memStData_i;
      r_fifoBe[r_wrPtr]   <= dc2memStByteEn_i;
    end
  end

  // Store FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Control FSM: load capture, store drain, line fill and response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state            <= S_IDLE;
      r_beat             <= '0;
      r_ldPending        <= 1'b0;
      r_ldAddr           <= '0;
      r_lineBuf          <= '0;
      mem2dcLdTag_o      <= '0;
      mem2dcLdIndex_o    <= '0;
      mem2dcLdData_o     <= '0;
      mem2dcLdValid_o    <= 1'b0;
      mem2dcStComplete_o <= 1'b0;
      memRdEn_o          <= 1'b0;
      memRdAddr_o        <= '0;
      memWrEn_o          <= 1'b0;
      memWrAddr_o        <= '0;
      memWrData_o        <= '0;
      memWrByteEn_o      <= '0;
    end else begin
      mem2dcLdValid_o    <= 1'b0;
      mem2dcStComplete_o <= 1'b0;
      memRdEn_o          <= 1'b0;

      // Only one miss is ever outstanding; extra requests are ignored.
      if (dc2memLdValid_i && !r_ldPending) begin
        r_ldPending <= 1'b1;
        r_ldAddr    <= dc2memLdAddr_i;
      end

      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            r_state       <= S_ST_REQ;
            memWrEn_o     <= 1'b1;
            memWrAddr_o   <= r_fifoAddr[r_rdPtr];
            memWrData_o   <= r_fifoData[r_rdPtr];
            memWrByteEn_o <= r_fifoBe[r_rdPtr];
          end else if (r_ldPending) begin
            r_state     <= S_LD_REQ;
            memRdEn_o   <= 1'b1;
            memRdAddr_o <= {r_ldAddr, r_beat};
          end
        end
        S_ST_REQ: begin
          if (memWrAck_i) begin
            memWrEn_o          <= 1'b0;
            mem2dcStComplete_o <= 1'b1;
            r_state            <= S_IDLE;
          end
        end
        S_LD_REQ: begin
          r_state <= S_LD_WAIT;
        end
        S_LD_WAIT: begin
          if (memRdValid_i) begin
            r_lineBuf[r_beat] <= memRdData_i;
            r_beat            <= w_beatNext;
            if (r_beat == '1) begin
              r_state <= S_LD_RESP;
            end else begin
              r_state     <= S_LD_REQ;
              memRdEn_o   <= 1'b1;
              memRdAddr_o <= {r_ldAddr, w_beatNext};
            end
          end
        end
        S_LD_RESP: begin
          mem2dcLdValid_o <= 1'b1;
          mem2dcLdTag_o   <= r_ldAddr[c_LINE_A_W-1:INDEX_W];
          mem2dcLdIndex_o <= r_ldAddr[INDEX_W-1:0];
          mem2dcLdData_o  <= r_lineBuf;
          r_ldPending     <= 1'b0;
          r_beat          <= '0;
          r_state         <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DCACHE_MEM_RESP_PERF_EN
  // Saturating event counters for fills, completed stores and stall cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perfLdLines_o    <= '0;
      perfStores_o     <= '0;
      perfStStallCyc_o <= '0;
    end else begin
      if (mem2dcLdValid_o && (perfLdLines_o != 32'hFFFF_FFFF))
        perfLdLines_o <= perfLdLines_o + 32'd1;
      if (mem2dcStComplete_o && (perfStores_o != 32'hFFFF_FFFF))
        perfStores_o <= perfStores_o + 32'd1;
      if (w_stall && (perfStStallCyc_o != 32'hFFFF_FFFF))
        perfStStallCyc_o <= perfStStallCyc_o + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dcache_mem_responder
// Brief    : Directed self-checking bench for dcache_mem_responder with a
//            behavioural backing memory (read latency 1, write ack latency 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_mem_responder;

  localparam int TAG_W = 21;
  localparam int INDEX_W = 7;
  localparam int WORDS_LOG = 3;
  localparam int ST_FIFO_LOG = 2;
  localparam int AW = TAG_W + INDEX_W + WORDS_LOG;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [TAG_W+INDEX_W-1:0] dc2memLdAddr_i = '0;
  logic dc2memLdValid_i = 1'b0;
  logic [TAG_W-1:0] mem2dcLdTag_o;
  logic [INDEX_W-1:0] mem2dcLdIndex_o;
  logic [255:0] mem2dcLdData_o;
  logic mem2dcLdValid_o;
  logic [AW-1:0] dc2memStAddr_i = '0;
  logic [31:0] dc2memStData_i = '0;
  logic [3:0] dc2memStByteEn_i = '0;
  logic dc2memStValid_i = 1'b0;
  logic mem2dcStComplete_o;
  logic mem2dcStStall_o;
  logic memRdEn_o;
  logic [AW-1:0] memRdAddr_o;
  logic [31:0] memRdData_i = '0;
  logic memRdValid_i = 1'b0;
  logic memWrEn_o;
  logic [AW-1:0] memWrAddr_o;
  logic [31:0] memWrData_o;
  logic [3:0] memWrByteEn_o;
  logic memWrAck_i = 1'b0;
`ifdef DCACHE_MEM_RESP_PERF_EN
  logic [31:0] perfLdLines_o, perfStores_o, perfStStallCyc_o;
`endif

  dcache_mem_responder #(
    .TAG_W(TAG_W), .INDEX_W(INDEX_W), .WORDS_LOG(WORDS_LOG), .ST_FIFO_LOG(ST_FIFO_LOG)
  ) dut (
    .clk(clk), .reset(reset),
    .dc2memLdAddr_i(dc2memLdAddr_i), .dc2memLdValid_i(dc2memLdValid_i),
    .mem2dcLdTag_o(mem2dcLdTag_o), .mem2dcLdIndex_o(mem2dcLdIndex_o),
    .mem2dcLdData_o(mem2dcLdData_o), .mem2dcLdValid_o(mem2dcLdValid_o),
    .dc2memStAddr_i(dc2memStAddr_i), .dc2memStData_i(dc2memStData_i),
    .dc2memStByteEn_i(dc2memStByteEn_i), .dc2memStValid_i(dc2memStValid_i),
    .mem2dcStComplete_o(mem2dcStComplete_o), .mem2dcStStall_o(mem2dcStStall_o),
    .memRdEn_o(memRdEn_o), .memRdAddr_o(memRdAddr_o),
    .memRdData_i(memRdData_i), .memRdValid_i(memRdValid_i),
    .memWrEn_o(memWrEn_o), .memWrAddr_o(memWrAddr_o), .memWrData_o(memWrData_o),
    .memWrByteEn_o(memWrByteEn_o), .memWrAck_i(memWrAck_i)
`ifdef DCACHE_MEM_RESP_PERF_EN
    , .perfLdLines_o(perfLdLines_o), .perfStores_o(perfStores_o),
    .perfStStallCyc_o(perfStStallCyc_o)
`endif
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail = 0;

  // Backing memory: unwritten words read back as their own word address.
  logic [31:0] bmem [int];
  logic [AW-1:0] rdLog[$];
  logic [AW-1:0] wrA[$];
  logic [31:0] wrD[$];
  logic [3:0] wrB[$];
  int wrAtFirstRd = -1;
  logic ackHold = 1'b0;
  logic pendRd = 1'b0;
  logic [AW-1:0] pendAddr = '0;

  function automatic logic [31:0] rdWord(input logic [AW-1:0] a);
    if (bmem.exists(int'(a))) return bmem[int'(a)];
    return 32'(a);
  endfunction

  initial begin
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        pendRd = 1'b0; memRdValid_i = 1'b0; memWrAck_i = 1'b0;
      end else begin
        memRdValid_i = pendRd;
        memRdData_i = pendRd ? rdWord(pendAddr) : 32'h0;
        pendRd = memRdEn_o;
        pendAddr = memRdAddr_o;
        if (memRdEn_o) begin
          if (rdLog.size() == 0) wrAtFirstRd = wrA.size();
          rdLog.push_back(memRdAddr_o);
        end
        if (memWrAck_i) memWrAck_i = 1'b0;
        else if (memWrEn_o && !ackHold) begin
          logic [31:0] w;
          memWrAck_i = 1'b1;
          w = rdWord(memWrAddr_o);
          for (int b = 0; b < 4; b++)
            if (memWrByteEn_o[b]) w[8*b +: 8] = memWrData_o[8*b +: 8];
          bmem[int'(memWrAddr_o)] = w;
          wrA.push_back(memWrAddr_o); wrD.push_back(memWrData_o); wrB.push_back(memWrByteEn_o);
        end
      end
    end
  end

  // Pulse monitor, sampled shortly after each rising edge.
  int ldPulses = 0;
  int stPulses = 0;
  logic [TAG_W-1:0] lastTag = '0;
  logic [INDEX_W-1:0] lastIdx = '0;
  logic [255:0] lastLine = '0;
  initial begin
    forever begin
      @(posedge clk); #2;
      if (mem2dcLdValid_o) begin
        ldPulses++; lastTag = mem2dcLdTag_o; lastIdx = mem2dcLdIndex_o; lastLine = mem2dcLdData_o;
      end
      if (mem2dcStComplete_o) stPulses++;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ldReq(input logic [TAG_W+INDEX_W-1:0] a);
    dc2memLdAddr_i = a; dc2memLdValid_i = 1'b1;
    @(negedge clk); dc2memLdValid_i = 1'b0;
  endtask

  task automatic stPush(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    dc2memStAddr_i = a; dc2memStData_i = d; dc2memStByteEn_i = be; dc2memStValid_i = 1'b1;
    @(negedge clk); dc2memStValid_i = 1'b0;
  endtask

  task automatic waitLd(input int target, input string tag);
    int k = 0;
    while (ldPulses < target && k < 300) begin @(negedge clk); k++; end
    chk(tag, 256'(ldPulses), 256'(target));
  endtask

  task automatic waitSt(input int target, input string tag);
    int k = 0;
    while (stPulses < target && k < 300) begin @(negedge clk); k++; end
    chk(tag, 256'(stPulses), 256'(target));
  endtask

  function automatic logic [255:0] expLine(input logic [TAG_W+INDEX_W-1:0] la);
    logic [255:0] l;
    logic [AW-1:0] base;
    base = {la, 3'b000};
    for (int i = 0; i < 8; i++) l[32*i +: 32] = 32'(base + AW'(i));
    return l;
  endfunction

  logic [TAG_W+INDEX_W-1:0] la;
  logic [255:0] el;
  logic [AW-1:0] sA [5];
  logic [31:0] sD [5];
  logic [3:0] sB [5];
  int k;
  int p0;

  initial begin
    // ---- reset state
    #2;
    chk("rst_ldValid", 256'(mem2dcLdValid_o), 0);
    chk("rst_stall", 256'(mem2dcStStall_o), 0);
    chk("rst_rdEn", 256'(memRdEn_o), 0);
    chk("rst_wrEn", 256'(memWrEn_o), 0);
    chk("rst_complete", 256'(mem2dcStComplete_o), 0);
    chk("rst_ldData", mem2dcLdData_o, 0);
    @(negedge clk); @(negedge clk); reset = 1'b1; @(negedge clk);

    // ---- basic line fill
    la = {21'h1A2B3, 7'h15};
    rdLog.delete();
    ldReq(la);
    chk("ld_stall_pending", 256'(mem2dcStStall_o), 1);
    waitLd(1, "ld_pulse");
    chk("ld_tag", 256'(lastTag), 256'(21'h1A2B3));
    chk("ld_index", 256'(lastIdx), 256'(7'h15));
    chk("ld_base_addr", 256'({la, 3'b000}), 256'(31'h068ACCA8));
    chk("ld_line", lastLine, expLine(la));
    chk("ld_nreads", 256'(rdLog.size()), 8);
    for (int i = 0; i < 8; i++) chk("ld_rd_addr", 256'(rdLog[i]), 256'(31'h068ACCA8 + 31'(i)));
    repeat (20) @(negedge clk);
    chk("ld_single_pulse", 256'(ldPulses), 1);
    chk("ld_hold_tag", 256'(mem2dcLdTag_o), 256'(21'h1A2B3));
    chk("ld_stall_clear", 256'(mem2dcStStall_o), 0);

    // ---- reset during LD_WAIT of beat 3
    la = {21'h00055, 7'h02};
    rdLog.delete();
    ldReq(la);
    k = 0;
    while (rdLog.size() < 4 && k < 100) begin @(negedge clk); k++; end
    chk("rstmid_reach_beat3", 256'(rdLog.size()), 4);
    @(negedge clk);
    reset = 1'b0; #1;
    chk("rstmid_ldData", mem2dcLdData_o, 0);
    chk("rstmid_tag", 256'(mem2dcLdTag_o), 0);
    chk("rstmid_stall", 256'(mem2dcStStall_o), 0);
    chk("rstmid_rdEn", 256'(memRdEn_o), 0);
    @(negedge clk); @(negedge clk); reset = 1'b1; @(negedge clk);
    p0 = ldPulses;
    repeat (30) @(negedge clk);
    chk("rstmid_no_pulse", 256'(ldPulses), 256'(p0));
    ldReq(la);
    waitLd(p0 + 1, "rstmid_refill_pulse");
    chk("rstmid_refill_line", lastLine, expLine(la));
    chk("rstmid_refill_index", 256'(lastIdx), 256'(7'h02));

    // ---- five stores against a held ack: four accepted, fifth dropped
    ackHold = 1'b1; wrA.delete(); wrD.delete(); wrB.delete();
    p0 = stPulses;
    for (int i = 0; i < 5; i++) begin
      sA[i] = AW'(32'h100 + i); sD[i] = 32'hA5A50000 + 32'(i); sB[i] = (i == 1) ? 4'b0110 : 4'b1001;
    end
    for (int i = 0; i < 4; i++) stPush(sA[i], sD[i], sB[i]);
    chk("st_stall_full", 256'(mem2dcStStall_o), 1);
    stPush(sA[4], sD[4], sB[4]);
    repeat (4) @(negedge clk);
    chk("st_wrEn_held", 256'(memWrEn_o), 1);
    chk("st_no_write_held", 256'(wrA.size()), 0);
    ackHold = 1'b0;
    waitSt(p0 + 4, "st_complete_cnt");
    repeat (10) @(negedge clk);
    chk("st_nwrites", 256'(wrA.size()), 4);
    for (int i = 0; i < 4; i++) begin
      chk("st_wr_addr", 256'(wrA[i]), 256'(sA[i]));
      chk("st_wr_data", 256'(wrD[i]), 256'(sD[i]));
      chk("st_wr_be", 256'(wrB[i]), 256'(sB[i]));
    end
    chk("st_complete_final", 256'(stPulses), 256'(p0 + 4));
    chk("st_stall_drained", 256'(mem2dcStStall_o), 0);

    // ---- full FIFO with a store held valid across the ack release
    ackHold = 1'b1; wrA.delete(); wrD.delete(); wrB.delete();
    p0 = stPulses;
    for (int i = 0; i < 5; i++) begin
      sA[i] = AW'(32'h200 + i); sD[i] = 32'h5A5A0000 + 32'(i); sB[i] = 4'(i + 3);
    end
    for (int i = 0; i < 4; i++) stPush(sA[i], sD[i], sB[i]);
    dc2memStAddr_i = sA[4]; dc2memStData_i = sD[4]; dc2memStByteEn_i = sB[4]; dc2memStValid_i = 1'b1;
    @(negedge clk);
    chk("pp_stall_full", 256'(mem2dcStStall_o), 1);
    ackHold = 1'b0;
    k = 0;
    while (mem2dcStStall_o && k < 50) begin @(negedge clk); k++; end
    chk("pp_stall_drop", 256'(mem2dcStStall_o), 0);
    @(negedge clk); dc2memStValid_i = 1'b0;
    chk("pp_stall_refull", 256'(mem2dcStStall_o), 1);
    waitSt(p0 + 5, "pp_complete_cnt");
    repeat (5) @(negedge clk);
    chk("pp_nwrites", 256'(wrA.size()), 5);
    for (int i = 0; i < 5; i++) chk("pp_wr_addr", 256'(wrA[i]), 256'(sA[i]));
    chk("pp_wr_data4", 256'(wrD[4]), 256'(32'h5A5A0004));

    // ---- store then load of the same line: store drains first
    wrA.delete(); wrD.delete(); wrB.delete(); rdLog.delete(); wrAtFirstRd = -1;
    p0 = ldPulses;
    stPush(AW'(32'h40), 32'hDEADBEEF, 4'hF);
    ldReq({21'h0, 7'h08});
    chk("sl_stall_with_load", 256'(mem2dcStStall_o), 1);
    waitLd(p0 + 1, "sl_pulse");
    chk("sl_write_before_read", 256'(wrAtFirstRd), 1);
    el = expLine({21'h0, 7'h08});
    el[31:0] = 32'hDEADBEEF;
    chk("sl_line", lastLine, el);
    chk("sl_index", 256'(lastIdx), 256'(7'h08));

    // ---- second load while one is pending is ignored
    repeat (3) @(negedge clk);
    rdLog.delete();
    p0 = ldPulses;
`ifdef DCACHE_MEM_RESP_PERF_EN
    k = int'(perfLdLines_o);
`endif
    ldReq({21'h00777, 7'h33});
    @(negedge clk);
    ldReq({21'h00888, 7'h44});
    waitLd(p0 + 1, "dbl_pulse");
    repeat (60) @(negedge clk);
    chk("dbl_single_pulse", 256'(ldPulses), 256'(p0 + 1));
    chk("dbl_tag", 256'(lastTag), 256'(21'h00777));
    chk("dbl_nreads", 256'(rdLog.size()), 8);
    chk("dbl_line", lastLine, expLine({21'h00777, 7'h33}));
`ifdef DCACHE_MEM_RESP_PERF_EN
    chk("perf_ld_delta", 256'(int'(perfLdLines_o) - k), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
`default_nettype wire
